// File: rtl/sys_job_seq.sv
// Job sequencer for the 4-PE systolic array: programs MAX/RUN, starts the array,
// polls run_status until it clears, and shares the iobuf dma_io port with the host.
module sys_job_seq #(
  parameter int unsigned POLL_GAP = 4,
  parameter logic [15:0] TIMEOUT  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_max,
  input  logic [7:0]  cmd_run,
  input  logic        host_we,
  input  logic [13:0] host_wadr,
  input  logic [31:0] host_wdata,
  input  logic        host_re,
  input  logic [13:0] host_radr,
  output logic [31:0] host_rdata,
  output logic        host_wait,
  output logic        dma_io_we,
  output logic [13:0] dma_io_wadr,
  output logic [31:0] dma_io_wdata,
  output logic [13:0] dma_io_radr,
  input  logic [31:0] dma_io_rdata,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  input  logic        err_clr
);

  localparam logic [13:0] ADR_STATUS = 14'h3FF8;
  localparam logic [13:0] ADR_MAX    = 14'h3FF9;
  localparam logic [13:0] ADR_RUN    = 14'h3FFA;
  localparam logic [7:0]  GAP_LAST   = 8'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WR_MAX, S_WR_RUN, S_WR_START, S_GAP, S_POLL, S_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  max_reg, run_reg;
  logic [15:0] tcnt_reg, tcnt_next;
  logic [7:0]  gcnt_reg, gcnt_next;
  logic        timeout_hit;
  logic        seq_we, seq_rd;
  logic [13:0] seq_wadr;
  logic [31:0] seq_wdata;
  logic        ctl_hit, host_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      max_reg     <= 8'd0;
      run_reg     <= 8'd0;
      tcnt_reg    <= 16'd0;
      gcnt_reg    <= 8'd0;
      err_timeout <= 1'b0;
    end else begin
      state_reg <= state_next;
      tcnt_reg  <= tcnt_next;
      gcnt_reg  <= gcnt_next;
      if (state_reg == S_IDLE && cmd_valid) begin
        max_reg <= cmd_max;
        run_reg <= cmd_run;
      end
      if (timeout_hit)
        err_timeout <= 1'b1;
      else if (err_clr)
        err_timeout <= 1'b0;
    end
  end

  always_comb begin
    state_next  = state_reg;
    tcnt_next   = tcnt_reg;
    gcnt_next   = gcnt_reg;
    timeout_hit = 1'b0;
    seq_we      = 1'b0;
    seq_rd      = 1'b0;
    seq_wadr    = 14'd0;
    seq_wdata   = 32'd0;
    case (state_reg)
      S_IDLE:  if (cmd_valid) state_next = S_CHECK;
      S_CHECK: begin
        seq_rd = 1'b1;
        if (!dma_io_rdata[0]) state_next = S_WR_MAX;
      end
      S_WR_MAX: begin
        seq_we     = 1'b1;
        seq_wadr   = ADR_MAX;
        seq_wdata  = {24'd0, max_reg};
        state_next = S_WR_RUN;
      end
      S_WR_RUN: begin
        seq_we     = 1'b1;
        seq_wadr   = ADR_RUN;
        seq_wdata  = {24'd0, run_reg};
        state_next = S_WR_START;
      end
      S_WR_START: begin
        seq_we     = 1'b1;
        seq_wadr   = ADR_STATUS;
        seq_wdata  = 32'd1;
        tcnt_next  = 16'd0;
        gcnt_next  = 8'd0;
        state_next = S_GAP;
      end
      S_GAP: begin
        tcnt_next = tcnt_reg + 16'd1;
        if (gcnt_reg == GAP_LAST) begin
          gcnt_next  = 8'd0;
          state_next = S_POLL;
        end else begin
          gcnt_next = gcnt_reg + 8'd1;
        end
      end
      S_POLL: begin
        seq_rd     = 1'b1;
        tcnt_next  = tcnt_reg + 16'd1;
        state_next = dma_io_rdata[0] ? S_GAP : S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // The counter value reached this cycle ends the job, overriding any poll result.
    if ((state_reg == S_GAP || state_reg == S_POLL) && tcnt_next == TIMEOUT) begin
      timeout_hit = 1'b1;
      state_next  = S_DONE;
    end
  end

  assign cmd_ready = (state_reg == S_IDLE);
  assign busy      = (state_reg != S_IDLE);
  assign done      = (state_reg == S_DONE);

  // Host writes to the control block must not disturb a job in flight.
  assign ctl_hit    = (host_wadr >= ADR_STATUS) && (host_wadr <= ADR_RUN);
  assign host_stall = host_we & busy & ctl_hit;

  assign host_wait    = (seq_we & host_we) | (seq_rd & host_re) | host_stall;
  assign dma_io_we    = seq_we | (host_we & ~host_stall);
  assign dma_io_wadr  = seq_we ? seq_wadr  : host_wadr;
  assign dma_io_wdata = seq_we ? seq_wdata : host_wdata;
  assign dma_io_radr  = seq_rd ? ADR_STATUS : host_radr;
  assign host_rdata   = dma_io_rdata;

endmodule

// File: tb/tb_sys_job_seq.sv
// Directed bench for sys_job_seq with a small iobuf model whose run_status
// bit is raised by a START write and drops after 20 cycles (or sticks).
module tb_sys_job_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_max = 8'd0;
  logic [7:0]  cmd_run = 8'd0;
  logic        host_we = 1'b0;
  logic [13:0] host_wadr = 14'd0;
  logic [31:0] host_wdata = 32'd0;
  logic        host_re = 1'b0;
  logic [13:0] host_radr = 14'd0;
  logic [31:0] host_rdata;
  logic        host_wait;
  logic        dma_io_we;
  logic [13:0] dma_io_wadr;
  logic [31:0] dma_io_wdata;
  logic [13:0] dma_io_radr;
  logic [31:0] dma_io_rdata;
  logic        busy;
  logic        done;
  logic        err_timeout;
  logic        err_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  typedef struct {
    logic [13:0] adr;
    logic [31:0] data;
    int          cyc;
  } wr_t;
  wr_t wq[$];

  logic stat_bit = 1'b0;
  bit   stat_force = 1'b0;
  bit   stat_stick = 1'b0;
  int   stat_cnt = 0;

  localparam logic [31:0] HD = 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  sys_job_seq #(.POLL_GAP(4), .TIMEOUT(16'd50)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_max(cmd_max), .cmd_run(cmd_run),
    .host_we(host_we), .host_wadr(host_wadr), .host_wdata(host_wdata),
    .host_re(host_re), .host_radr(host_radr), .host_rdata(host_rdata), .host_wait(host_wait),
    .dma_io_we(dma_io_we), .dma_io_wadr(dma_io_wadr), .dma_io_wdata(dma_io_wdata),
    .dma_io_radr(dma_io_radr), .dma_io_rdata(dma_io_rdata),
    .busy(busy), .done(done), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  assign dma_io_rdata = (dma_io_radr == 14'h3FF8) ? {31'd0, stat_bit | stat_force}
                                                  : (32'h1234_0000 | {18'd0, dma_io_radr});

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (dma_io_we && dma_io_wadr == 14'h3FF8 && dma_io_wdata[0]) begin
      stat_bit <= 1'b1;
      stat_cnt <= 20;
    end else begin
      if (stat_cnt > 0) stat_cnt <= stat_cnt - 1;
      if (stat_cnt <= 1 && !stat_stick) stat_bit <= 1'b0;
    end
  end

  always @(negedge clk) begin
    #2;
    if (dma_io_we) wq.push_back('{adr: dma_io_wadr, data: dma_io_wdata, cyc: cyc});
    if (done) done_cnt++;
  end

  task automatic accept_job(input logic [7:0] m, input logic [7:0] r, input bit hold,
                            output bit ok, output int acyc);
    ok = 1'b0;
    acyc = 0;
    @(negedge clk);
    cmd_max = m;
    cmd_run = r;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (cmd_ready) begin
        ok = 1'b1;
        acyc = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit seen, output int dcyc);
    seen = 1'b0;
    dcyc = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        dcyc = cyc;
        break;
      end
    end
  endtask

  task automatic wait_start(output bit seen, output int scyc);
    seen = 1'b0;
    scyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (dma_io_we && dma_io_wadr == 14'h3FF8 && dma_io_wdata == 32'd1) begin
        seen = 1'b1;
        scyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err_timeout !== 1'b0 || dma_io_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b busy=%b done=%b err=%b we=%b, want 1 0 0 0 0",
               cmd_ready, busy, done, err_timeout, dma_io_we);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("test_reset: done");
  endtask

  task automatic test_single_job();
    bit ok, seen;
    int acyc, dcyc, d0;
    wq.delete();
    d0 = done_cnt;
    accept_job(8'h10, 8'h05, 1'b0, ok, acyc);
    wait_done(200, seen, dcyc);
    checks++;
    if (!ok || !seen) begin
      errors++;
      $display("FAIL job1_complete: accepted=%b done_seen=%b, want 1 1", ok, seen);
    end
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (wq.size() != 3) begin
      errors++;
      $display("FAIL job1_writes: count=%0d, want 3", wq.size());
    end else begin
      if (wq[0].adr !== 14'h3FF9 || wq[0].data !== 32'h10 || wq[1].adr !== 14'h3FFA ||
          wq[1].data !== 32'h05 || wq[2].adr !== 14'h3FF8 || wq[2].data !== 32'h1) begin
        errors++;
        $display("FAIL job1_writes: %h=%h %h=%h %h=%h, want 3ff9=10 3ffa=05 3ff8=1",
                 wq[0].adr, wq[0].data, wq[1].adr, wq[1].data, wq[2].adr, wq[2].data);
      end
      checks++;
      if (wq[2].cyc != acyc + 4) begin
        errors++;
        $display("FAIL job1_start_latency: got %0d cycles, want 4", wq[2].cyc - acyc);
      end
    end
    checks++;
    if (done_cnt != d0 + 1 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL job1_done: pulses=%0d err=%b, want 1 0", done_cnt - d0, err_timeout);
    end
    $display("test_single_job: done");
  endtask

  task automatic test_status_busy();
    bit ok, seen;
    int acyc, dcyc;
    stat_force = 1'b1;
    wq.delete();
    accept_job(8'h22, 8'h07, 1'b0, ok, acyc);
    repeat (10) @(negedge clk);
    #3;
    checks++;
    if (!ok || wq.size() != 0 || busy !== 1'b1 || dma_io_radr !== 14'h3FF8) begin
      errors++;
      $display("FAIL check_hold: ok=%b writes=%0d busy=%b radr=%h, want 1 0 1 3ff8",
               ok, wq.size(), busy, dma_io_radr);
    end
    stat_force = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (dma_io_we !== 1'b1 || dma_io_wadr !== 14'h3FF9 || dma_io_wdata !== 32'h22) begin
      errors++;
      $display("FAIL check_release: we=%b wadr=%h wdata=%h, want 1 3ff9 22",
               dma_io_we, dma_io_wadr, dma_io_wdata);
    end
    wait_done(200, seen, dcyc);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL check_job_done: done_seen=%b, want 1", seen);
    end
    $display("test_status_busy: done");
  endtask

  task automatic test_host_stall();
    bit ok, found, released, leak;
    int acyc;
    wq.delete();
    accept_job(8'h00, 8'h33, 1'b0, ok, acyc);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (dma_io_we && dma_io_wadr == 14'h3FFA) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL stall_find_wr_run: found=%b, want 1", found);
    end
    host_wadr = 14'h3FF9;
    host_wdata = HD;
    host_we = 1'b1;
    #1;
    checks++;
    if (host_wait !== 1'b1 || dma_io_wadr !== 14'h3FFA || dma_io_wdata !== 32'h33) begin
      errors++;
      $display("FAIL stall_wr_run: wait=%b wadr=%h wdata=%h, want 1 3ffa 33",
               host_wait, dma_io_wadr, dma_io_wdata);
    end
    @(negedge clk);
    host_we = 1'b0;
    #1;
    checks++;
    if (dma_io_wadr !== 14'h3FF8 || dma_io_wdata !== 32'd1) begin
      errors++;
      $display("FAIL stall_start: wadr=%h wdata=%h, want 3ff8 1", dma_io_wadr, dma_io_wdata);
    end
    @(negedge clk);
    host_radr = 14'h1000;
    host_re = 1'b1;
    #1;
    checks++;
    if (host_wait !== 1'b0 || dma_io_radr !== 14'h1000 || host_rdata !== 32'h1234_1000) begin
      errors++;
      $display("FAIL gap_read: wait=%b radr=%h rdata=%h, want 0 1000 12341000",
               host_wait, dma_io_radr, host_rdata);
    end
    @(negedge clk);
    host_re = 1'b0;
    host_we = 1'b1;
    released = 1'b0;
    leak = 1'b0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (!busy) begin
        released = 1'b1;
        break;
      end
      if (!host_wait || (dma_io_we && dma_io_wdata == HD)) leak = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (!released || leak) begin
      errors++;
      $display("FAIL gap_write_stall: released=%b leaked=%b, want 1 0", released, leak);
    end
    checks++;
    if (dma_io_we !== 1'b1 || dma_io_wadr !== 14'h3FF9 || dma_io_wdata !== HD || host_wait !== 1'b0) begin
      errors++;
      $display("FAIL host_write_after_done: we=%b wadr=%h wdata=%h wait=%b, want 1 3ff9 deadbeef 0",
               dma_io_we, dma_io_wadr, dma_io_wdata, host_wait);
    end
    @(negedge clk);
    host_we = 1'b0;
    checks++;
    if (wq.size() < 1 || wq[0].adr !== 14'h3FF9 || wq[0].data !== 32'd0) begin
      errors++;
      $display("FAIL max_zero_issued: writes=%0d first=%h, want first 3ff9=0",
               wq.size(), (wq.size() > 0) ? wq[0].data : 32'hFFFF_FFFF);
    end
    $display("test_host_stall: done");
  endtask

  task automatic test_timeout();
    bit ok, seen, sseen;
    int acyc, scyc, dcyc;
    stat_stick = 1'b1;
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pre: err=%b, want 0", err_timeout);
    end
    accept_job(8'h44, 8'h66, 1'b0, ok, acyc);
    wait_start(sseen, scyc);
    wait_done(200, seen, dcyc);
    checks++;
    if (!sseen || !seen || dcyc - scyc != 51) begin
      errors++;
      $display("FAIL timeout_latency: start=%b done=%b cycles=%0d, want 1 1 51",
               sseen, seen, dcyc - scyc);
    end
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_flag: err=%b, want 1", err_timeout);
    end
    stat_stick = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky: err=%b busy=%b, want 1 0", err_timeout, busy);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: err=%b, want 0", err_timeout);
    end
    $display("test_timeout: done");
  endtask

  task automatic test_reset_mid_job();
    bit ok, seen, sseen;
    int acyc, scyc, dcyc, d0;
    accept_job(8'h55, 8'h0A, 1'b0, ok, acyc);
    wait_start(sseen, scyc);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (!sseen || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 ||
        err_timeout !== 1'b0 || dma_io_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_gap: start=%b busy=%b ready=%b done=%b err=%b we=%b, want 1 0 1 0 0 0",
               sseen, busy, cmd_ready, done, err_timeout, dma_io_we);
    end
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    #3;
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL reset_no_done: pulses=%0d, want 0", done_cnt - d0);
    end
    wq.delete();
    accept_job(8'h5A, 8'h0B, 1'b0, ok, acyc);
    wait_done(200, seen, dcyc);
    @(negedge clk);
    #3;
    checks++;
    if (!ok || !seen || wq.size() != 3 || wq[0].data !== 32'h5A || wq[1].data !== 32'h0B) begin
      errors++;
      $display("FAIL reset_fresh_job: ok=%b done=%b writes=%0d, want 1 1 3 with 5a,0b",
               ok, seen, wq.size());
    end
    $display("test_reset_mid_job: done");
  endtask

  task automatic test_back_to_back();
    bit ok, seen;
    int acyc, acyc2, dcyc;
    wq.delete();
    accept_job(8'h61, 8'h62, 1'b1, ok, acyc);
    cmd_max = 8'h71;
    cmd_run = 8'h72;
    wait_done(200, seen, dcyc);
    checks++;
    if (!ok || !seen || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_cycle: ok=%b done=%b ready=%b, want 1 1 0", ok, seen, cmd_ready);
    end
    @(negedge clk);
    #1;
    acyc2 = cyc;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_cycle: ready=%b busy=%b, want 1 0", cmd_ready, busy);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_accept: busy=%b, want 1", busy);
    end
    wait_done(200, seen, dcyc);
    @(negedge clk);
    #3;
    checks++;
    if (!seen || wq.size() != 6) begin
      errors++;
      $display("FAIL b2b_writes: done=%b count=%0d, want 1 6", seen, wq.size());
    end else if (wq[0].data !== 32'h61 || wq[1].data !== 32'h62 || wq[3].adr !== 14'h3FF9 ||
                 wq[3].data !== 32'h71 || wq[4].data !== 32'h72 || wq[5].adr !== 14'h3FF8 ||
                 wq[5].cyc != acyc2 + 4) begin
      errors++;
      $display("FAIL b2b_writes: %h %h | %h=%h %h %h start_lat=%0d, want 61 62 | 3ff9=71 72 3ff8 4",
               wq[0].data, wq[1].data, wq[3].adr, wq[3].data, wq[4].data, wq[5].adr, wq[5].cyc - acyc2);
    end
    $display("test_back_to_back: done");
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_status_busy();
    test_host_stall();
    test_timeout();
    test_reset_mid_job();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
